eeprom_mitm_logic: RTL and testbench
====================================

# eeprom_mitm_logic

Parametrised successor of the proprietary-EEPROM MITM decision logic. Sits between the bus-control chunk engine and the mode selector: commands the bus controller chunk by chunk (instruction, address, data words), decides per data word whether MISO is substituted, and hands back pass-through control with `cmd_finish`. Adds inclusive address-window substitution, multi-word burst-read tracking with address auto-increment, and a substitution counter.

## Interface
- `INSTR_WIDTH`, 3: opcode bits per instruction chunk
- `ADDR_WIDTH`, 9: address bits per address chunk
- `DATA_WIDTH`, 8: bits per data word
- `BUF_SIZE`, 9: data bus width; must be ≥ max of the three widths above
- `CNT_WIDTH`, 16: substitution counter width
- `sys_clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `mode_select` in 3: one-hot mode, `001` FORWARD, `010` SUB_ALL, `100` SUB_RANGE
- `comm_active` in 1: bus transaction in progress (CS asserted)
- `bus_ready` in 1: bus controller idle / chunk complete
- `real_miso_data`, `real_mosi_data` in BUF_SIZE: last completed chunk, LSB-aligned
- `match_lo`, `match_hi` in ADDR_WIDTH: inclusive substitution window
- `sub_data` in DATA_WIDTH: replacement data word
- `cmd_next_chunk` out 1: 1-cycle pulse, request chunk of `next_chunk_size` bits
- `cmd_finish` out 1: 1-cycle pulse, forward the rest of the transaction transparently
- `next_chunk_size` out $clog2(BUF_SIZE+1): size of the requested chunk
- `fake_miso_select`, `fake_mosi_select` out 1: substitute the line during the current chunk
- `fake_miso_data`, `fake_mosi_data` out BUF_SIZE: substitute values
- `sub_count` out CNT_WIDTH: substituted data words since reset, saturating
- `cur_addr` out ADDR_WIDTH: address of the current or last data word

## Operation
- States: IDLE, INSTR, ADDR, DATA, PASS. Each chunk state has two phases: issue, then wait.
- IDLE: on `comm_active`&`bus_ready`, latch `mode_select`, pulse `cmd_next_chunk`, size INSTR_WIDTH, go to INSTR.
- A chunk completes when `bus_ready` is seen low after the command pulse, then high again. The completing edge captures `real_mosi_data`.
- INSTR done: opcode = `real_mosi_data[INSTR_WIDTH-1:0]`.
  - READ (`3'b110`): request an ADDR_WIDTH chunk.
  - Any other opcode (e.g. WRITE `3'b101`): pulse `cmd_finish`, go to PASS.
- ADDR done: load `cur_addr`.
  - FORWARD: `cmd_finish` → PASS.
  - SUB modes: request a DATA_WIDTH chunk.
- DATA chunk:
  - match = SUB_ALL, or SUB_RANGE with `match_lo ≤ cur_addr ≤ match_hi`. `match_lo > match_hi` never matches.
  - On match: `fake_miso_select`=1, `fake_miso_data`={zeros, `sub_data`}, and `sub_count`+1 at completion.
  - On completion with `comm_active` high: `cur_addr`+1, wrapping modulo 2^ADDR_WIDTH. Request the next DATA chunk, re-evaluating match.
- PASS: wait for `comm_active` low → IDLE.
- `comm_active` falling in any state: abort to IDLE next edge. Clear selects; no `cmd_finish`.
- `fake_mosi_select`=0 and `fake_mosi_data`=0 always; these ports are reserved.
- Mode changes mid-transaction are ignored until the next IDLE exit.

## Timing
- Reset: all outputs 0, state IDLE. Reset mid-transaction: immediate, asynchronous.
- Start latency: `comm_active`&`bus_ready` sampled at edge N → `cmd_next_chunk` high for cycle N+1 only.
- Chunk turnaround: completion at edge M → next `cmd_next_chunk` or `cmd_finish` in cycle M+1.
- `next_chunk_size` is registered and valid with the pulse. It holds until the next pulse.
- `fake_miso_select` and data rise with the DATA `cmd_next_chunk` pulse and hold until completion. They clear at M+1 unless the next chunk also matches.
- `bus_ready` never dropping after a command: wait indefinitely. Only `comm_active` low or reset exits.
- `sub_count` saturates at all-ones.

## Structure
- Package `mitm_pkg`: mode encodings, READ/WRITE opcodes, state enum, chunk-size width function.
- Sub-module `mitm_addr_tracker`: load, increment with wrap, range compare, and `cur_addr` register.

## Test plan
- FORWARD: READ `110`, addr `0x14A` → two `cmd_next_chunk` pulses (sizes 3, 9), then `cmd_finish`, selects always 0.
- SUB_ALL, `sub_data`=`0x5A`, 3-word burst from `0x1FF` → `cur_addr` 0x1FF, 0x000, 0x001; select=1 each word; `fake_miso_data`=`0x05A`; `sub_count`=3.
- SUB_RANGE, window 0x010–0x011, burst from 0x00F, 4 words → select 0,1,1,0; `sub_count`+2.
- WRITE `101` in SUB_ALL → one 3-bit chunk, then `cmd_finish`; no DATA chunk; `sub_count` unchanged.
- `comm_active` dropped mid-ADDR chunk → IDLE next cycle, no `cmd_finish`; the next transaction starts normally.
- Reset asserted mid-DATA chunk with select high → all outputs 0 immediately; counter cleared.

Source files
------------

// File: rtl/mitm_pkg.sv
// Shared encodings for the EEPROM MITM decision logic: modes, opcodes,
// controller states and the chunk-size width helper.
package mitm_pkg;

  localparam logic [2:0] MODE_FORWARD   = 3'b001;
  localparam logic [2:0] MODE_SUB_ALL   = 3'b010;
  localparam logic [2:0] MODE_SUB_RANGE = 3'b100;

  localparam logic [2:0] OP_READ  = 3'b110;
  localparam logic [2:0] OP_WRITE = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_DATA,
    ST_PASS
  } state_t;

  function automatic int chunk_size_width(input int buf_size);
    return $clog2(buf_size + 1);
  endfunction

endpackage

// File: rtl/eeprom_mitm_logic_if.sv
// Chunk-engine handshake between the MITM decision logic (master) and the
// bus controller (slave).
interface eeprom_mitm_logic_if #(
  parameter int BUF_SIZE   = 9,
  parameter int SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);

  logic                  comm_active;
  logic                  bus_ready;
  logic [BUF_SIZE-1:0]   real_miso_data;
  logic [BUF_SIZE-1:0]   real_mosi_data;
  logic                  cmd_next_chunk;
  logic                  cmd_finish;
  logic [SIZE_WIDTH-1:0] next_chunk_size;
  logic                  fake_miso_select;
  logic                  fake_mosi_select;
  logic [BUF_SIZE-1:0]   fake_miso_data;
  logic [BUF_SIZE-1:0]   fake_mosi_data;

  modport master (
    input  comm_active, bus_ready, real_miso_data, real_mosi_data,
    output cmd_next_chunk, cmd_finish, next_chunk_size,
           fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
  );

  modport slave (
    output comm_active, bus_ready, real_miso_data, real_mosi_data,
    input  cmd_next_chunk, cmd_finish, next_chunk_size,
           fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
  );

endinterface

// File: rtl/mitm_addr_tracker.sv
// Current data-word address: load from the address chunk, wrap-around
// increment per burst word, and inclusive window compare.
module mitm_addr_tracker #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [ADDR_WIDTH-1:0] match_lo,
  input  logic [ADDR_WIDTH-1:0] match_hi,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  load_in_window,
  output logic                  next_in_window
);

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;

  // An inverted window (lo > hi) can never satisfy both bounds.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] lo,
                                     input logic [ADDR_WIDTH-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign addr_next      = addr_reg + 1'b1;
  assign load_in_window = in_window(load_addr, match_lo, match_hi);
  assign next_in_window = in_window(addr_next, match_lo, match_hi);
  assign cur_addr       = addr_reg;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= load_addr;
    end else if (inc) begin
      addr_reg <= addr_next;
    end
  end

endmodule

// File: rtl/eeprom_mitm_logic.sv
// MITM decision logic: walks instruction/address/data chunks through the bus
// controller, substitutes MISO on matching read words, then hands back control.
module eeprom_mitm_logic
  import mitm_pkg::*;
#(
  parameter int INSTR_WIDTH = 3,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int BUF_SIZE    = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  eeprom_mitm_logic_if.master   bus,
  input  logic [2:0]            mode_select,
  input  logic [ADDR_WIDTH-1:0] match_lo,
  input  logic [ADDR_WIDTH-1:0] match_hi,
  input  logic [DATA_WIDTH-1:0] sub_data,
  output logic [CNT_WIDTH-1:0]  sub_count,
  output logic [ADDR_WIDTH-1:0] cur_addr
);

  localparam int SIZE_W = chunk_size_width(BUF_SIZE);

  state_t              state_reg;
  logic [2:0]          mode_reg;
  logic                seen_low_reg;
  logic                cmd_next_reg;
  logic                cmd_finish_reg;
  logic [SIZE_W-1:0]   size_reg;
  logic                sel_reg;
  logic [BUF_SIZE-1:0] fdata_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  logic chunk_done;
  logic addr_load;
  logic addr_inc;
  logic load_in_window;
  logic next_in_window;
  logic sub_all;
  logic sub_range;
  logic match_first;
  logic match_next;
  logic [BUF_SIZE-1:0] sub_word;

  assign chunk_done  = seen_low_reg && bus.bus_ready;
  assign addr_load   = (state_reg == ST_ADDR) && bus.comm_active && chunk_done;
  assign addr_inc    = (state_reg == ST_DATA) && bus.comm_active && chunk_done;
  assign sub_all     = (mode_reg == MODE_SUB_ALL);
  assign sub_range   = (mode_reg == MODE_SUB_RANGE);
  assign match_first = sub_all || (sub_range && load_in_window);
  assign match_next  = sub_all || (sub_range && next_in_window);
  assign sub_word    = BUF_SIZE'(sub_data);

  mitm_addr_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_tracker (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .load           (addr_load),
    .inc            (addr_inc),
    .load_addr      (bus.real_mosi_data[ADDR_WIDTH-1:0]),
    .match_lo       (match_lo),
    .match_hi       (match_hi),
    .cur_addr       (cur_addr),
    .load_in_window (load_in_window),
    .next_in_window (next_in_window)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= '0;
      seen_low_reg   <= 1'b0;
      cmd_next_reg   <= 1'b0;
      cmd_finish_reg <= 1'b0;
      size_reg       <= '0;
      sel_reg        <= 1'b0;
      fdata_reg      <= '0;
      count_reg      <= '0;
    end else begin
      cmd_next_reg   <= 1'b0;
      cmd_finish_reg <= 1'b0;
      // Wait phase: a chunk is done only once bus_ready has dipped low.
      if (!bus.bus_ready) begin
        seen_low_reg <= 1'b1;
      end
      if (state_reg == ST_IDLE) begin
        if (bus.comm_active && bus.bus_ready) begin
          mode_reg     <= mode_select;
          cmd_next_reg <= 1'b1;
          size_reg     <= SIZE_W'(INSTR_WIDTH);
          seen_low_reg <= 1'b0;
          state_reg    <= ST_INSTR;
        end
      end else if (!bus.comm_active) begin
        state_reg <= ST_IDLE;
        sel_reg   <= 1'b0;
        fdata_reg <= '0;
      end else if (chunk_done && state_reg != ST_PASS) begin
        case (state_reg)
          ST_INSTR: begin
            if (bus.real_mosi_data[INSTR_WIDTH-1:0] == INSTR_WIDTH'(OP_READ)) begin
              cmd_next_reg <= 1'b1;
              size_reg     <= SIZE_W'(ADDR_WIDTH);
              seen_low_reg <= 1'b0;
              state_reg    <= ST_ADDR;
            end else begin
              cmd_finish_reg <= 1'b1;
              state_reg      <= ST_PASS;
            end
          end
          ST_ADDR: begin
            if (sub_all || sub_range) begin
              cmd_next_reg <= 1'b1;
              size_reg     <= SIZE_W'(DATA_WIDTH);
              seen_low_reg <= 1'b0;
              sel_reg      <= match_first;
              fdata_reg    <= match_first ? sub_word : '0;
              state_reg    <= ST_DATA;
            end else begin
              cmd_finish_reg <= 1'b1;
              state_reg      <= ST_PASS;
            end
          end
          ST_DATA: begin
            if (sel_reg && (count_reg != {CNT_WIDTH{1'b1}})) begin
              count_reg <= count_reg + 1'b1;
            end
            cmd_next_reg <= 1'b1;
            size_reg     <= SIZE_W'(DATA_WIDTH);
            seen_low_reg <= 1'b0;
            sel_reg      <= match_next;
            fdata_reg    <= match_next ? sub_word : '0;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_next_chunk   = cmd_next_reg;
  assign bus.cmd_finish       = cmd_finish_reg;
  assign bus.next_chunk_size  = size_reg;
  assign bus.fake_miso_select = sel_reg;
  assign bus.fake_miso_data   = fdata_reg;
  assign bus.fake_mosi_select = 1'b0;
  assign bus.fake_mosi_data   = '0;
  assign sub_count            = count_reg;

endmodule

// File: tb/tb_eeprom_mitm_logic.sv
// Directed bench for eeprom_mitm_logic: a simple bus-controller model walks
// chunks and every expected value is hand-computed.
module tb_eeprom_mitm_logic;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b0;
  logic [2:0]  mode_select = 3'b000;
  logic [8:0]  match_lo = '0;
  logic [8:0]  match_hi = '0;
  logic [7:0]  sub_data = '0;
  logic [15:0] sub_count;
  logic [8:0]  cur_addr;

  int vectors     = 0;
  int miscompares = 0;
  int exp_count   = 0;
  int txn         = 0;

  eeprom_mitm_logic_if #(.BUF_SIZE(9)) bus_if ();

  eeprom_mitm_logic #(
    .INSTR_WIDTH (3),
    .ADDR_WIDTH  (9),
    .DATA_WIDTH  (8),
    .BUF_SIZE    (9),
    .CNT_WIDTH   (16)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .bus         (bus_if.master),
    .mode_select (mode_select),
    .match_lo    (match_lo),
    .match_hi    (match_hi),
    .sub_data    (sub_data),
    .sub_count   (sub_count),
    .cur_addr    (cur_addr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic log_txn(input string what);
    txn++;
    $display("txn %0d: %s, sub_count=%0d cur_addr=0x%03h", txn, what, sub_count, cur_addr);
  endtask

  // Start a transaction; the command pulse must appear one cycle later.
  task automatic start_txn(input logic [2:0] mode);
    mode_select = mode;
    bus_if.comm_active = 1'b1;
    bus_if.bus_ready   = 1'b1;
    tick();
    check_vec("start_pulse", 32'(bus_if.cmd_next_chunk), 1);
    check_vec("start_size", 32'(bus_if.next_chunk_size), 3);
  endtask

  // Serve one requested chunk; returns right after the completing edge.
  task automatic do_chunk(input string tag, input logic [8:0] mosi, input int exp_size,
                          input logic exp_sel, input logic [8:0] exp_data);
    int waited = 0;
    while (!bus_if.cmd_next_chunk && waited < 20) begin
      tick();
      waited++;
    end
    check_vec({tag, "_cmd_seen"}, 32'(bus_if.cmd_next_chunk), 1);
    check_vec({tag, "_size"}, 32'(bus_if.next_chunk_size), 32'(exp_size));
    check_vec({tag, "_sel"}, 32'(bus_if.fake_miso_select), 32'(exp_sel));
    if (exp_sel) check_vec({tag, "_data"}, 32'(bus_if.fake_miso_data), 32'(exp_data));
    bus_if.bus_ready = 1'b0;
    tick();
    check_vec({tag, "_pulse_end"}, 32'(bus_if.cmd_next_chunk), 0);
    check_vec({tag, "_sel_hold"}, 32'(bus_if.fake_miso_select), 32'(exp_sel));
    bus_if.real_mosi_data = mosi;
    bus_if.bus_ready = 1'b1;
    tick();
  endtask

  task automatic end_txn();
    bus_if.comm_active = 1'b0;
    tick();
    check_vec("end_sel", 32'(bus_if.fake_miso_select), 0);
    check_vec("end_no_finish", 32'(bus_if.cmd_finish), 0);
    tick();
  endtask

  initial begin
    bus_if.comm_active    = 1'b0;
    bus_if.bus_ready      = 1'b0;
    bus_if.real_miso_data = '0;
    bus_if.real_mosi_data = '0;
    #12;
    check_vec("rst_cmd_next", 32'(bus_if.cmd_next_chunk), 0);
    check_vec("rst_cmd_finish", 32'(bus_if.cmd_finish), 0);
    check_vec("rst_size", 32'(bus_if.next_chunk_size), 0);
    check_vec("rst_sel", 32'(bus_if.fake_miso_select), 0);
    check_vec("rst_count", 32'(sub_count), 0);
    check_vec("rst_addr", 32'(cur_addr), 0);
    rst = 1'b1;
    tick();
    tick();

    // FORWARD read of 0x14A
    start_txn(3'b001);
    do_chunk("fw_instr", 9'h006, 3, 1'b0, 9'h000);
    check_vec("fw_turn_addr", 32'(bus_if.cmd_next_chunk), 1);
    do_chunk("fw_addr", 9'h14A, 9, 1'b0, 9'h000);
    check_vec("fw_finish", 32'(bus_if.cmd_finish), 1);
    check_vec("fw_no_next", 32'(bus_if.cmd_next_chunk), 0);
    check_vec("fw_cur_addr", 32'(cur_addr), 32'h14A);
    check_vec("fw_mosi_sel", 32'(bus_if.fake_mosi_select), 0);
    tick();
    check_vec("fw_finish_end", 32'(bus_if.cmd_finish), 0);
    end_txn();
    log_txn("FORWARD read 0x14A");

    // SUB_ALL 3-word burst wrapping from 0x1FF
    sub_data = 8'h5A;
    start_txn(3'b010);
    do_chunk("sa_instr", 9'h006, 3, 1'b0, 9'h000);
    do_chunk("sa_addr", 9'h1FF, 9, 1'b0, 9'h000);
    check_vec("sa_addr0", 32'(cur_addr), 32'h1FF);
    do_chunk("sa_d0", 9'h000, 8, 1'b1, 9'h05A);
    exp_count++;
    check_vec("sa_addr1", 32'(cur_addr), 32'h000);
    do_chunk("sa_d1", 9'h000, 8, 1'b1, 9'h05A);
    exp_count++;
    check_vec("sa_addr2", 32'(cur_addr), 32'h001);
    do_chunk("sa_d2", 9'h000, 8, 1'b1, 9'h05A);
    exp_count++;
    check_vec("sa_count", 32'(sub_count), 32'(exp_count));
    end_txn();
    log_txn("SUB_ALL burst from 0x1FF");

    // SUB_RANGE window 0x010..0x011, 4 words from 0x00F
    match_lo = 9'h010;
    match_hi = 9'h011;
    start_txn(3'b100);
    do_chunk("sr_instr", 9'h006, 3, 1'b0, 9'h000);
    do_chunk("sr_addr", 9'h00F, 9, 1'b0, 9'h000);
    do_chunk("sr_d0", 9'h000, 8, 1'b0, 9'h000);
    do_chunk("sr_d1", 9'h000, 8, 1'b1, 9'h05A);
    do_chunk("sr_d2", 9'h000, 8, 1'b1, 9'h05A);
    do_chunk("sr_d3", 9'h000, 8, 1'b0, 9'h000);
    exp_count += 2;
    check_vec("sr_count", 32'(sub_count), 32'(exp_count));
    check_vec("sr_cur_addr", 32'(cur_addr), 32'h013);
    end_txn();
    log_txn("SUB_RANGE burst from 0x00F");

    // WRITE in SUB_ALL: one instruction chunk then hand-back
    start_txn(3'b010);
    do_chunk("wr_instr", 9'h005, 3, 1'b0, 9'h000);
    check_vec("wr_finish", 32'(bus_if.cmd_finish), 1);
    check_vec("wr_no_next", 32'(bus_if.cmd_next_chunk), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("wr_no_data_chunk", 32'(bus_if.cmd_next_chunk), 0);
    end
    check_vec("wr_count", 32'(sub_count), 32'(exp_count));
    end_txn();
    log_txn("WRITE in SUB_ALL");

    // Abort during the address chunk
    start_txn(3'b001);
    do_chunk("ab_instr", 9'h006, 3, 1'b0, 9'h000);
    bus_if.bus_ready = 1'b0;
    tick();
    bus_if.comm_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("ab_no_finish", 32'(bus_if.cmd_finish), 0);
      check_vec("ab_no_next", 32'(bus_if.cmd_next_chunk), 0);
    end
    log_txn("abort mid-ADDR");

    // Next transaction after abort, inverted window never matches
    match_lo = 9'h005;
    match_hi = 9'h003;
    start_txn(3'b100);
    do_chunk("inv_instr", 9'h006, 3, 1'b0, 9'h000);
    do_chunk("inv_addr", 9'h004, 9, 1'b0, 9'h000);
    do_chunk("inv_d0", 9'h000, 8, 1'b0, 9'h000);
    check_vec("inv_sel", 32'(bus_if.fake_miso_select), 0);
    check_vec("inv_count", 32'(sub_count), 32'(exp_count));
    end_txn();
    log_txn("SUB_RANGE inverted window");

    // Reset mid-DATA with select high
    start_txn(3'b010);
    do_chunk("rs_instr", 9'h006, 3, 1'b0, 9'h000);
    do_chunk("rs_addr", 9'h020, 9, 1'b0, 9'h000);
    check_vec("rs_sel_up", 32'(bus_if.fake_miso_select), 1);
    bus_if.bus_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_vec("rs_sel", 32'(bus_if.fake_miso_select), 0);
    check_vec("rs_data", 32'(bus_if.fake_miso_data), 0);
    check_vec("rs_count", 32'(sub_count), 0);
    check_vec("rs_addr", 32'(cur_addr), 0);
    check_vec("rs_size", 32'(bus_if.next_chunk_size), 0);
    #1;
    rst = 1'b1;
    bus_if.bus_ready = 1'b1;
    tick();
    check_vec("rs_restart", 32'(bus_if.cmd_next_chunk), 1);
    check_vec("rs_restart_size", 32'(bus_if.next_chunk_size), 3);
    end_txn();
    log_txn("reset mid-DATA");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
